moore_step_counter: RTL



---
 rtl/moore_step_counter_pkg.sv | 14 +
 rtl/moore_step_counter_if.sv | 15 +
 rtl/moore_step_counter_edge_oneshot.sv | 66 ++++++
 rtl/moore_step_counter.sv | 106 ++++++++++
 4 files changed

// File: rtl/moore_step_counter_pkg.sv
// Shared state encoding for the push-button driven modulo step counter.
package moore_step_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'b00;
  localparam logic [1:0] ST_STEP_ENC = 2'b01;
  localparam logic [1:0] ST_WRAP_ENC = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE_ENC,
    STEP = ST_STEP_ENC,
    WRAP = ST_WRAP_ENC
  } state_t;

endpackage

// File: rtl/moore_step_counter_if.sv
// Step request / count output bundle between the board buttons and the display logic.
interface moore_step_counter_if #(
  parameter int WIDTH = 4,
  parameter int CW    = 2
);
  logic             PBen;
  logic             Dir;
  logic [WIDTH-1:0] OUT;
  logic [CW-1:0]    Cout;
  logic             Wrap;
  logic             Busy;

  modport master (output PBen, output Dir, input OUT, input Cout, input Wrap, input Busy);
  modport slave  (input PBen, input Dir, output OUT, output Cout, output Wrap, output Busy);
endinterface

// File: rtl/moore_step_counter_edge_oneshot.sv
// Two-flop synchroniser, optional debounce filter, registered rising-edge pulse.
// Optional feature: `define DEBOUNCE_EN inserts a DB_CYCLES stability filter.
module edge_oneshot #(
  parameter int DB_CYCLES = 4
) (
  input  logic Clk,
  input  logic PBrst,
  input  logic din,
  output logic pulse
);

  logic sync1_q;
  logic sync2_q;
  logic lvl_s;
  logic lvl_q;
  logic pulse_q;

  if (DB_CYCLES < 1) begin : g_db_cycles_invalid
    $error("edge_oneshot: DB_CYCLES must be >= 1");
  end

  always_ff @(posedge Clk) begin
    if (!PBrst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_s;
      pulse_q <= lvl_s & ~lvl_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

  logic             filt_q;
  logic [CNT_W-1:0] cnt_q;

  // The filtered level flips only once the raw level has disagreed for DB_CYCLES edges in a row.
  always_ff @(posedge Clk) begin
    if (!PBrst) begin
      filt_q <= 1'b0;
      cnt_q  <= {CNT_W{1'b0}};
    end else if (sync2_q != filt_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        filt_q <= sync2_q;
        cnt_q  <= {CNT_W{1'b0}};
      end else begin
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_q <= {CNT_W{1'b0}};
    end
  end

  assign lvl_s = filt_q;
`else
  assign lvl_s = sync2_q;
`endif

  assign pulse = pulse_q;

endmodule

// File: rtl/moore_step_counter.sv
// Moore step counter: one modulo-MOD step per button press, saturating wrap counter.
// Optional feature: `define DEBOUNCE_EN enables the input debounce filter.
import moore_step_pkg::*;

module moore_step_counter #(
  parameter int WIDTH     = 4,
  parameter int MOD       = 10,
  parameter int CW        = 2,
  parameter int DB_CYCLES = 4
) (
  input  logic                 Clk,
  input  logic                 PBrst,
  moore_step_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [CW-1:0]    COUT_SAT = {CW{1'b1}};

  if (MOD < 2 || MOD > (2 ** WIDTH) || CW < 1) begin : g_param_invalid
    $error("moore_step_counter: MOD must be 2..2**WIDTH and CW >= 1");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cout_q, cout_d;
  logic             pending_q, pending_d;
  logic             wrap_q, busy_q;
  logic             pulse_s;
  logic             go_s;

  edge_oneshot #(
    .DB_CYCLES (DB_CYCLES)
  ) u_oneshot (
    .Clk   (Clk),
    .PBrst (PBrst),
    .din   (bus.PBen),
    .pulse (pulse_s)
  );

  always_ff @(posedge Clk) begin
    if (!PBrst) begin
      state_q   <= IDLE;
      out_q     <= ZERO_VAL;
      cout_q    <= {CW{1'b0}};
      pending_q <= 1'b0;
      wrap_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      cout_q    <= cout_d;
      pending_q <= pending_d;
      wrap_q    <= (state_d == WRAP);
      busy_q    <= (state_d != IDLE);
    end
  end

  // A pulse seen while busy is held in pending (one deep) and taken in the next IDLE cycle.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    cout_d    = cout_q;
    pending_d = pending_q;
    go_s      = pulse_s | pending_q;
    case (state_q)
      IDLE: begin
        if (go_s) begin
          pending_d = 1'b0;
          if ((bus.Dir && (out_q == MAX_VAL)) || (!bus.Dir && (out_q == ZERO_VAL))) begin
            state_d = WRAP;
            out_d   = bus.Dir ? ZERO_VAL : MAX_VAL;
            if (cout_q != COUT_SAT) begin
              cout_d = cout_q + CW'(1);
            end else begin
              cout_d = cout_q;
            end
          end else begin
            state_d = STEP;
            out_d   = bus.Dir ? (out_q + WIDTH'(1)) : (out_q - WIDTH'(1));
          end
        end else begin
          state_d = IDLE;
        end
      end
      STEP, WRAP: begin
        state_d = IDLE;
        if (pulse_s) begin
          pending_d = 1'b1;
        end else begin
          pending_d = pending_q;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  assign bus.OUT  = out_q;
  assign bus.Cout = cout_q;
  assign bus.Wrap = wrap_q;
  assign bus.Busy = busy_q;

endmodule
